// File: rtl/rv32i_ex_stage_pkg.sv
// Shared constants and types for the RV32I execute stage: opcode classes,
// funct3 codes, bus widths and the shift-sequencer state encoding.
package rv32i_ex_stage_pkg;

    localparam int ALU_OP_BUS_W   = 7;
    localparam int ALU_FUN3_BUS_W = 3;
    localparam int DATA_BUS_W     = 32;
    localparam int REG_ADDR_BUS_W = 5;

    localparam logic [ALU_OP_BUS_W-1:0] OP_R     = 7'b0110011;
    localparam logic [ALU_OP_BUS_W-1:0] OP_I     = 7'b0010011;
    localparam logic [ALU_OP_BUS_W-1:0] OP_LOAD  = 7'b0000011;
    localparam logic [ALU_OP_BUS_W-1:0] OP_STORE = 7'b0100011;
    localparam logic [ALU_OP_BUS_W-1:0] OP_LUI   = 7'b0110111;
    localparam logic [ALU_OP_BUS_W-1:0] OP_AUIPC = 7'b0010111;

    localparam logic [ALU_FUN3_BUS_W-1:0] F3_ADD_SUB = 3'b000;
    localparam logic [ALU_FUN3_BUS_W-1:0] F3_SLL     = 3'b001;
    localparam logic [ALU_FUN3_BUS_W-1:0] F3_SLT     = 3'b010;
    localparam logic [ALU_FUN3_BUS_W-1:0] F3_SLTU    = 3'b011;
    localparam logic [ALU_FUN3_BUS_W-1:0] F3_XOR     = 3'b100;
    localparam logic [ALU_FUN3_BUS_W-1:0] F3_SRL_SRA = 3'b101;
    localparam logic [ALU_FUN3_BUS_W-1:0] F3_OR      = 3'b110;
    localparam logic [ALU_FUN3_BUS_W-1:0] F3_AND     = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ex_state_e;

    function automatic logic is_shift_op(input logic [ALU_OP_BUS_W-1:0] aluop,
                                         input logic [ALU_FUN3_BUS_W-1:0] fun3);
        return ((aluop == OP_R) || (aluop == OP_I)) &&
               ((fun3 == F3_SLL) || (fun3 == F3_SRL_SRA));
    endfunction

endpackage

// File: rtl/rv32i_ex_stage_serial_shifter.sv
// One-bit-per-cycle shifter: load captures operand, amount and direction;
// result_o is the accumulator advanced by one more step.
module rv32i_serial_shifter #(
    parameter int DATA_W = 32,
    parameter int SH_W   = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [SH_W-1:0]   shamt_i,
    input  logic              right_i,
    input  logic              arith_i,
    output logic [DATA_W-1:0] result_o,
    output logic              last_o
);

    logic [DATA_W-1:0] acc_q;
    logic [SH_W-1:0]   cnt_q;
    logic              right_q;
    logic              arith_q;
    logic [DATA_W-1:0] acc_step;

    always_comb begin
        if (right_q) begin
            acc_step = {arith_q & acc_q[DATA_W-1], acc_q[DATA_W-1:1]};
        end else begin
            acc_step = {acc_q[DATA_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            right_q <= 1'b0;
            arith_q <= 1'b0;
        end else if (load_i) begin
            acc_q   <= data_i;
            cnt_q   <= shamt_i;
            right_q <= right_i;
            arith_q <= arith_i;
        end else if (cnt_q != '0) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q - SH_W'(1);
        end
    end

    // The final step is taken combinationally so the result lands in the
    // output register on the same edge that the count runs out.
    assign result_o = acc_step;
    assign last_o   = (cnt_q == SH_W'(1));

endmodule

// File: rtl/rv32i_ex_stage.sv
// RV32I execute stage and EX/MEM register. Define RV32I_EX_BARREL_SHIFT_EN
// for a single-cycle barrel shifter instead of the stalling serial shifter.
module rv32i_ex_stage
    import rv32i_ex_stage_pkg::*;
#(
    parameter int DATA_W = DATA_BUS_W,
    parameter int REG_AW = REG_ADDR_BUS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_we,
    input  logic [REG_AW-1:0] ex_waddr,
    input  logic [6:0]        ex_aluop,
    input  logic [2:0]        ex_alufun3,
    input  logic              ex_alufun7,
    input  logic [DATA_W-1:0] ex_alu1,
    input  logic [DATA_W-1:0] ex_alu2,
    input  logic              ex_memce,
    input  logic              ex_memwe,
    input  logic [DATA_W-1:0] ex_memdata,
    input  logic [DATA_W-1:0] ex_offset,
    output logic              stall_req,
    output logic              mem_we,
    output logic [REG_AW-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ce,
    output logic              mem_memwe,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_memdata
);

    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0]   shamt;
    logic              shift_right;
    logic              shift_arith;
    logic [DATA_W-1:0] shift_value;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] result_sel;
    logic              bubble;
    logic              stall_raw;

    logic              we_q, we_d;
    logic [REG_AW-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ce_q, ce_d;
    logic              memwe_q, memwe_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] memdata_q, memdata_d;

    assign shamt       = ex_alu2[SH_W-1:0];
    assign shift_right = (ex_alufun3 == F3_SRL_SRA);
    assign shift_arith = shift_right & ex_alufun7;

`ifdef RV32I_EX_BARREL_SHIFT_EN
    always_comb begin
        if (!shift_right) begin
            shift_value = ex_alu1 << shamt;
        end else if (shift_arith) begin
            shift_value = DATA_W'($signed(ex_alu1) >>> shamt);
        end else begin
            shift_value = ex_alu1 >> shamt;
        end
    end

    assign result_sel = alu_result;
    assign bubble     = 1'b0;
    assign stall_raw  = 1'b0;
`else
    ex_state_e         state_q, state_d;
    logic              shift_op;
    logic              sh_load;
    logic              sh_last;
    logic [DATA_W-1:0] sh_result;

    // Only a zero-length shift reaches the single-cycle path here.
    assign shift_value = ex_alu1;
    assign shift_op    = is_shift_op(ex_aluop, ex_alufun3);

    rv32i_serial_shifter #(
        .DATA_W (DATA_W),
        .SH_W   (SH_W)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load_i   (sh_load),
        .data_i   (ex_alu1),
        .shamt_i  (shamt),
        .right_i  (shift_right),
        .arith_i  (shift_arith),
        .result_o (sh_result),
        .last_o   (sh_last)
    );

    always_comb begin
        state_d    = state_q;
        sh_load    = 1'b0;
        stall_raw  = 1'b0;
        bubble     = 1'b0;
        result_sel = alu_result;
        case (state_q)
            ST_IDLE: begin
                if (shift_op && (shamt != '0)) begin
                    sh_load   = 1'b1;
                    stall_raw = 1'b1;
                    bubble    = 1'b1;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sh_last) begin
                    result_sel = sh_result;
                    state_d    = ST_IDLE;
                end else begin
                    stall_raw = 1'b1;
                    bubble    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end
`endif

    // Holding the front of the pipe while reset is applied would be pointless.
    assign stall_req = stall_raw & ~rst;

    always_comb begin
        alu_result = '0;
        case (ex_aluop)
            OP_R, OP_I: begin
                case (ex_alufun3)
                    F3_ADD_SUB: alu_result = (ex_aluop == OP_R && ex_alufun7) ?
                                             ex_alu1 - ex_alu2 : ex_alu1 + ex_alu2;
                    F3_SLT:     alu_result = {{(DATA_W-1){1'b0}},
                                              $signed(ex_alu1) < $signed(ex_alu2)};
                    F3_SLTU:    alu_result = {{(DATA_W-1){1'b0}}, ex_alu1 < ex_alu2};
                    F3_XOR:     alu_result = ex_alu1 ^ ex_alu2;
                    F3_OR:      alu_result = ex_alu1 | ex_alu2;
                    F3_AND:     alu_result = ex_alu1 & ex_alu2;
                    F3_SLL,
                    F3_SRL_SRA: alu_result = shift_value;
                    default:    alu_result = '0;
                endcase
            end
            OP_LUI:   alu_result = ex_alu2;
            OP_AUIPC: alu_result = ex_alu1 + ex_alu2;
            default:  alu_result = '0;
        endcase
    end

    always_comb begin
        we_d      = ex_we;
        waddr_d   = ex_waddr;
        wdata_d   = result_sel;
        ce_d      = ex_memce;
        memwe_d   = ex_memwe;
        addr_d    = ex_alu1 + ex_offset;
        memdata_d = ex_memdata;
        if (bubble) begin
            we_d      = 1'b0;
            waddr_d   = '0;
            wdata_d   = '0;
            ce_d      = 1'b0;
            memwe_d   = 1'b0;
            addr_d    = '0;
            memdata_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            ce_q      <= 1'b0;
            memwe_q   <= 1'b0;
            addr_q    <= '0;
            memdata_q <= '0;
        end else begin
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            ce_q      <= ce_d;
            memwe_q   <= memwe_d;
            addr_q    <= addr_d;
            memdata_q <= memdata_d;
        end
    end

    assign mem_we      = we_q;
    assign mem_waddr   = waddr_q;
    assign mem_wdata   = wdata_q;
    assign mem_ce      = ce_q;
    assign mem_memwe   = memwe_q;
    assign mem_addr    = addr_q;
    assign mem_memdata = memdata_q;

endmodule

// File: tb/tb_rv32i_ex_stage.sv
// Self-checking bench for rv32i_ex_stage: directed scenarios plus random ops
// compared against a behavioural model of the execute stage.
module tb_rv32i_ex_stage;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_we = 1'b0;
    logic [4:0]  ex_waddr = '0;
    logic [6:0]  ex_aluop = '0;
    logic [2:0]  ex_alufun3 = '0;
    logic        ex_alufun7 = 1'b0;
    logic [31:0] ex_alu1 = '0;
    logic [31:0] ex_alu2 = '0;
    logic        ex_memce = 1'b0;
    logic        ex_memwe = 1'b0;
    logic [31:0] ex_memdata = '0;
    logic [31:0] ex_offset = '0;
    logic        stall_req;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_ce;
    logic        mem_memwe;
    logic [31:0] mem_addr;
    logic [31:0] mem_memdata;

    int checks = 0;
    int errors = 0;

    rv32i_ex_stage dut (
        .clk         (clk),
        .rst         (rst),
        .ex_we       (ex_we),
        .ex_waddr    (ex_waddr),
        .ex_aluop    (ex_aluop),
        .ex_alufun3  (ex_alufun3),
        .ex_alufun7  (ex_alufun7),
        .ex_alu1     (ex_alu1),
        .ex_alu2     (ex_alu2),
        .ex_memce    (ex_memce),
        .ex_memwe    (ex_memwe),
        .ex_memdata  (ex_memdata),
        .ex_offset   (ex_offset),
        .stall_req   (stall_req),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_ce      (mem_ce),
        .mem_memwe   (mem_memwe),
        .mem_addr    (mem_addr),
        .mem_memdata (mem_memdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_wdata(input logic [6:0] op, input logic [2:0] f3,
                                                input logic f7, input logic [31:0] a,
                                                input logic [31:0] b);
        logic [31:0] r;
        int s;
        s = int'(b[4:0]);
        r = 32'h0;
        if (op == OP_R || op == OP_I) begin
            case (f3)
                3'b000: r = (op == OP_R && f7) ? a - b : a + b;
                3'b010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'b011: r = (a < b) ? 32'd1 : 32'd0;
                3'b100: r = a ^ b;
                3'b110: r = a | b;
                3'b111: r = a & b;
                3'b001: r = a << s;
                default: begin
                    if (f7) r = $signed(a) >>> s;
                    else    r = a >> s;
                end
            endcase
        end else if (op == OP_LUI) begin
            r = b;
        end else if (op == OP_AUIPC) begin
            r = a + b;
        end
        return r;
    endfunction

    function automatic int model_stalls(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [31:0] b);
`ifdef RV32I_EX_BARREL_SHIFT_EN
        return 0;
`else
        if ((op == OP_R || op == OP_I) && (f3 == 3'b001 || f3 == 3'b101))
            return int'(b[4:0]);
        return 0;
`endif
    endfunction

    // Drives one op at a falling edge and returns at the falling edge after
    // its result edge, counting stall cycles and any non-bubble output seen.
    task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input logic [31:0] a, input logic [31:0] b, input logic we,
                          input logic [4:0] waddr, input logic ce, input logic memwe,
                          input logic [31:0] memdata, input logic [31:0] offset,
                          output int stalls, output bit bubble_bad, output bit timed_out);
        ex_aluop = op; ex_alufun3 = f3; ex_alufun7 = f7; ex_alu1 = a; ex_alu2 = b;
        ex_we = we; ex_waddr = waddr; ex_memce = ce; ex_memwe = memwe;
        ex_memdata = memdata; ex_offset = offset;
        stalls = 0; bubble_bad = 1'b0; timed_out = 1'b0;
        #1;
        while (stall_req === 1'b1) begin
            if (stalls >= 40) begin
                timed_out = 1'b1;
                break;
            end
            stalls++;
            @(negedge clk);
            if (mem_we !== 1'b0 || mem_ce !== 1'b0 || mem_memwe !== 1'b0) bubble_bad = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_we, mem_ce, mem_memwe} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=000", {mem_we, mem_ce, mem_memwe});
        end
        checks++;
        if ({mem_waddr, mem_wdata, mem_addr, mem_memdata} !== '0) begin
            errors++; $display("FAIL reset_data got waddr=%h wdata=%h addr=%h memdata=%h exp=0",
                               mem_waddr, mem_wdata, mem_addr, mem_memdata);
        end
        checks++;
        if (stall_req !== 1'b0) begin
            errors++; $display("FAIL reset_stall got=%b exp=0", stall_req);
        end
        rst = 1'b0;
        $display("reset: outputs checked");
    endtask

    task automatic test_add_sub();
        logic [6:0]  ops [3] = '{OP_R, OP_R, OP_I};
        logic        f7s [3] = '{1'b0, 1'b1, 1'b1};
        logic [31:0] exps[3] = '{32'd12, 32'hFFFFFFFE, 32'd12};
        int st; bit bb, to;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], 3'b000, f7s[i], 32'd5, 32'd7, 1'b1, 5'd3, 1'b0, 1'b0, '0, '0, st, bb, to);
            checks++;
            if (mem_wdata !== exps[i] || mem_we !== 1'b1 || mem_waddr !== 5'd3) begin
                errors++; $display("FAIL add_sub[%0d] got wdata=%h we=%b waddr=%0d exp wdata=%h we=1 waddr=3",
                                   i, mem_wdata, mem_we, mem_waddr, exps[i]);
            end
            checks++;
            if (st != 0) begin
                errors++; $display("FAIL add_sub_stall[%0d] got=%0d exp=0", i, st);
            end
            $display("add_sub[%0d]: op=%h fun7=%b wdata=%h", i, ops[i], f7s[i], mem_wdata);
        end
    endtask

    task automatic test_slt();
        logic [2:0]  f3s [2] = '{3'b010, 3'b011};
        logic [31:0] exps[2] = '{32'd1, 32'd0};
        int st; bit bb, to;
        for (int i = 0; i < 2; i++) begin
            run_op(OP_R, f3s[i], 1'b0, 32'hFFFFFFFF, 32'd1, 1'b1, 5'd4, 1'b0, 1'b0, '0, '0, st, bb, to);
            checks++;
            if (mem_wdata !== exps[i]) begin
                errors++; $display("FAIL slt[%0d] got=%h exp=%h", i, mem_wdata, exps[i]);
            end
            $display("slt: fun3=%b wdata=%h", f3s[i], mem_wdata);
        end
    endtask

    task automatic test_sra_stall();
        int st; bit bb, to;
        run_op(OP_R, 3'b101, 1'b1, 32'h80000000, 32'd4, 1'b1, 5'd9, 1'b0, 1'b0, '0, '0, st, bb, to);
        checks++;
        if (st != model_stalls(OP_R, 3'b101, 32'd4) || to) begin
            errors++; $display("FAIL sra_stall_cycles got=%0d timeout=%b exp=%0d",
                               st, to, model_stalls(OP_R, 3'b101, 32'd4));
        end
        checks++;
        if (bb) begin
            errors++; $display("FAIL sra_bubble got=non_bubble exp=bubble");
        end
        checks++;
        if (mem_wdata !== 32'hF8000000 || mem_we !== 1'b1 || mem_waddr !== 5'd9) begin
            errors++; $display("FAIL sra_result got wdata=%h we=%b waddr=%0d exp wdata=f8000000 we=1 waddr=9",
                               mem_wdata, mem_we, mem_waddr);
        end
        $display("sra: stalls=%0d wdata=%h", st, mem_wdata);
    endtask

    task automatic test_shift_boundaries();
        int st; bit bb, to;
        run_op(OP_R, 3'b101, 1'b0, 32'h00001234, 32'd0, 1'b1, 5'd5, 1'b0, 1'b0, '0, '0, st, bb, to);
        checks++;
        if (mem_wdata !== 32'h00001234 || st != 0) begin
            errors++; $display("FAIL shamt0 got wdata=%h stalls=%0d exp wdata=00001234 stalls=0", mem_wdata, st);
        end
        $display("shamt0: wdata=%h stalls=%0d", mem_wdata, st);
        run_op(OP_I, 3'b001, 1'b0, 32'd1, 32'h21, 1'b1, 5'd6, 1'b0, 1'b0, '0, '0, st, bb, to);
        checks++;
        if (mem_wdata !== 32'd2 || st != model_stalls(OP_I, 3'b001, 32'h21) || to || bb) begin
            errors++; $display("FAIL shamt_upper_ignored got wdata=%h stalls=%0d exp wdata=2 stalls=%0d",
                               mem_wdata, st, model_stalls(OP_I, 3'b001, 32'h21));
        end
        $display("sll 0x21: wdata=%h stalls=%0d", mem_wdata, st);
    endtask

    task automatic test_store();
        int st; bit bb, to;
        run_op(OP_STORE, 3'b010, 1'b0, 32'h1000, 32'h10, 1'b0, 5'd0, 1'b1, 1'b1, 32'hAB, 32'h10, st, bb, to);
        checks++;
        if (mem_addr !== 32'h1010 || mem_memdata !== 32'hAB) begin
            errors++; $display("FAIL store_addr got addr=%h memdata=%h exp addr=1010 memdata=ab", mem_addr, mem_memdata);
        end
        checks++;
        if ({mem_ce, mem_memwe, mem_we} !== 3'b110 || mem_wdata !== 32'h0) begin
            errors++; $display("FAIL store_ctrl got ce/memwe/we=%b wdata=%h exp 110 wdata=0",
                               {mem_ce, mem_memwe, mem_we}, mem_wdata);
        end
        $display("store: addr=%h memdata=%h", mem_addr, mem_memdata);
    endtask

    task automatic test_reset_mid_shift();
        int st; bit bb, to;
        ex_aluop = OP_R; ex_alufun3 = 3'b001; ex_alufun7 = 1'b0; ex_alu1 = 32'h5; ex_alu2 = 32'd20;
        ex_we = 1'b1; ex_waddr = 5'd7; ex_memce = 1'b0; ex_memwe = 1'b0; ex_offset = 32'h4;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_we, mem_ce, mem_memwe} !== 3'b000 || mem_wdata !== '0 || mem_addr !== '0) begin
            errors++; $display("FAIL midshift_reset got ctrl=%b wdata=%h addr=%h exp all 0",
                               {mem_we, mem_ce, mem_memwe}, mem_wdata, mem_addr);
        end
        checks++;
        if (stall_req !== 1'b0) begin
            errors++; $display("FAIL midshift_reset_stall got=%b exp=0", stall_req);
        end
        rst = 1'b0;
        run_op(OP_R, 3'b000, 1'b0, 32'd3, 32'd4, 1'b1, 5'd8, 1'b0, 1'b0, '0, '0, st, bb, to);
        checks++;
        if (mem_wdata !== 32'd7 || mem_we !== 1'b1 || mem_waddr !== 5'd8 || st != 0) begin
            errors++; $display("FAIL after_reset_add got wdata=%h we=%b waddr=%0d stalls=%0d exp 7/1/8/0",
                               mem_wdata, mem_we, mem_waddr, st);
        end
        $display("reset mid-shift: following add wdata=%h", mem_wdata);
    endtask

    task automatic test_back_to_back();
        int st; bit bb, to;
        run_op(OP_I, 3'b101, 1'b0, 32'hF0, 32'd3, 1'b1, 5'd10, 1'b0, 1'b0, '0, '0, st, bb, to);
        checks++;
        if (mem_wdata !== 32'h1E || st != model_stalls(OP_I, 3'b101, 32'd3) || to || bb) begin
            errors++; $display("FAIL b2b_first got wdata=%h stalls=%0d exp wdata=1e stalls=%0d",
                               mem_wdata, st, model_stalls(OP_I, 3'b101, 32'd3));
        end
        $display("b2b first: wdata=%h stalls=%0d", mem_wdata, st);
        run_op(OP_R, 3'b001, 1'b0, 32'h3, 32'd2, 1'b1, 5'd11, 1'b0, 1'b0, '0, '0, st, bb, to);
        checks++;
        if (mem_wdata !== 32'hC || mem_waddr !== 5'd11 || st != model_stalls(OP_R, 3'b001, 32'd2) || to || bb) begin
            errors++; $display("FAIL b2b_second got wdata=%h waddr=%0d stalls=%0d exp wdata=c waddr=11 stalls=%0d",
                               mem_wdata, mem_waddr, st, model_stalls(OP_R, 3'b001, 32'd2));
        end
        $display("b2b second: wdata=%h stalls=%0d", mem_wdata, st);
    endtask

    task automatic test_random();
        logic [6:0] op_tab [6] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC};
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7, we, ce, mwe;
        logic [4:0]  wa;
        logic [31:0] a, b, md, off, exp_w;
        int st, exp_st; bit bb, to;
        for (int n = 0; n < 60; n++) begin
            op  = op_tab[$urandom_range(0, 5)];
            f3  = 3'($urandom_range(0, 7));
            f7  = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
            we  = 1'($urandom_range(0, 1));
            ce  = 1'($urandom_range(0, 1));
            mwe = 1'($urandom_range(0, 1));
            wa  = 5'($urandom_range(0, 31));
            md  = $urandom;
            off = $urandom;
            exp_w  = model_wdata(op, f3, f7, a, b);
            exp_st = model_stalls(op, f3, b);
            run_op(op, f3, f7, a, b, we, wa, ce, mwe, md, off, st, bb, to);
            checks++;
            if (mem_wdata !== exp_w) begin
                errors++; $display("FAIL rand_wdata[%0d] op=%h f3=%b f7=%b a=%h b=%h got=%h exp=%h",
                                   n, op, f3, f7, a, b, mem_wdata, exp_w);
            end
            checks++;
            if (st != exp_st || to || bb) begin
                errors++; $display("FAIL rand_stall[%0d] got=%0d timeout=%b bubble_bad=%b exp=%0d",
                                   n, st, to, bb, exp_st);
            end
            checks++;
            if ({mem_we, mem_waddr, mem_ce, mem_memwe} !== {we, wa, ce, mwe} ||
                mem_addr !== a + off || mem_memdata !== md) begin
                errors++; $display("FAIL rand_ctrl[%0d] got we=%b wa=%0d ce=%b mwe=%b addr=%h md=%h exp %b %0d %b %b %h %h",
                                   n, mem_we, mem_waddr, mem_ce, mem_memwe, mem_addr, mem_memdata,
                                   we, wa, ce, mwe, a + off, md);
            end
            $display("rand[%0d]: op=%h f3=%b wdata=%h stalls=%0d", n, op, f3, mem_wdata, st);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_slt();
        test_sra_stall();
        test_shift_boundaries();
        test_store();
        test_reset_mid_shift();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32i_ex_stage.md
Name: rv32i_ex_stage

Overview:
- Execute stage placed directly downstream of the ID/EX pipeline register.
- Consumes the decoded operands and control fields, computes the ALU result or the load/store address, and registers the outputs toward the MEM stage, so it also acts as the EX/MEM boundary.
- Shifts are iterative, 1 bit per cycle; the block raises stall_req to hold the front of the pipe while a shift completes.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register-file address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ex_we  in  1  register write enable from ID/EX
- ex_waddr  in  REG_AW  destination register
- ex_aluop  in  7  opcode class (R, I, LOAD, STORE, LUI, AUIPC)
- ex_alufun3  in  3  funct3
- ex_alufun7  in  1  funct7[5] (SUB/SRA select)
- ex_alu1  in  DATA_W  operand 1 (rs1 or pc)
- ex_alu2  in  DATA_W  operand 2 (rs2 or imm)
- ex_memce  in  1  memory access enable
- ex_memwe  in  1  memory write enable
- ex_memdata  in  DATA_W  store data
- ex_offset  in  DATA_W  load/store immediate offset
- stall_req  out  1  hold the PC, IF/ID and ID/EX registers
- mem_we  out  1  register write enable to MEM
- mem_waddr  out  REG_AW  destination register
- mem_wdata  out  DATA_W  ALU result
- mem_ce  out  1  memory enable
- mem_memwe  out  1  memory write
- mem_addr  out  DATA_W  memory address = ex_alu1 + ex_offset
- mem_memdata  out  DATA_W  store data passthrough

Behaviour:
- Reset:
  - All mem_* outputs are 0.
  - State is IDLE, counter is 0, stall_req is 0.
  - A reset during SHIFT aborts the shift; no result is written.
- Single-cycle operations: inputs are sampled at a rising edge and mem_* outputs update at the same edge (1-cycle latency).
- funct3 decode:
  - 000: ADD; SUB only when aluop=OP_R and fun7=1 (I-type 000 is always ADD).
  - 010: SLT (signed).
  - 011: SLTU.
  - 100: XOR.
  - 110: OR.
  - 111: AND.
  - 001: SLL.
  - 101: SRL when fun7=0, SRA when fun7=1.
- Other opcodes:
  - LUI: result = alu2.
  - AUIPC: result = alu1 + alu2.
  - LOAD/STORE: mem_wdata = 0; address is computed.
- Arithmetic width rules:
  - All add/sub is mod 2^32.
  - SLT/SLTU produce {31'b0, flag}.
  - shamt = alu2[4:0]; upper bits are ignored.
- FSM states:
  - IDLE: if the incoming op is a shift with shamt != 0:
    - Load acc = alu1 and cnt = shamt.
    - Go to SHIFT.
    - stall_req = 1.
    - Outputs load a bubble (we/ce/memwe = 0).
  - SHIFT: each cycle acc shifts by 1 (SRA replicates the sign bit) and cnt decrements.
    - stall_req = (cnt != 1).
    - When cnt == 1: outputs load the final shifted value with the upstream control fields, then return to IDLE with stall_req = 0 that cycle.
- stall_req is combinational from state, cnt and the current inputs.
- A shift with shamt=0 is a single-cycle op: result = alu1, no stall.
- Shift latency is shamt+1 cycles; stall_req is high for exactly shamt cycles.
- Upstream holds its inputs stable while stall_req = 1.
- Every cycle with stall_req = 1 emits a bubble, so the destination register is never written twice.
- Back-to-back shifts: the second shift is sampled in IDLE right after return and starts a new sequence. There is no dead cycle other than the result cycle.

Optional Feature:
- Macro: RV32I_EX_BARREL_SHIFT_EN.
- Defined: combinational 32-bit barrel shifter; every op has 1-cycle latency; FSM and counter are removed; stall_req is tied to 0.
- Undefined: iterative shifter as described above.

Decomposition:
- Shared package/DEFINES holds:
  - Opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC.
  - funct3 constants.
  - AluOpBus / AluFun3Bus / DataBus / RegAddrBus widths.
  - FSM state encoding.
- One natural sub-module: rv32i_serial_shifter (acc, cnt, done), replaced by the barrel shifter under the macro.

Test Plan:
- ADD/SUB: alu1=5, alu2=7, R fun3=000 fun7=0 -> mem_wdata=12 next cycle. fun7=1 -> 0xFFFFFFFE. I-type with fun7=1 -> 12.
- SLT vs SLTU: alu1=0xFFFFFFFF, alu2=1 -> SLT=1, SLTU=0.
- SRA: alu1=0x80000000, alu2=4:
  - stall_req high for 4 cycles, mem_we=0 during the stall.
  - Cycle 5 edge: mem_wdata=0xF8000000, mem_we=1, written once.
- Shift boundaries: shamt=0 -> result=alu1, stall_req never asserted. alu2=0x21 (shamt=1) SLL of 1 -> 2.
- STORE: alu1=0x1000, offset=0x10, memdata=0xAB -> mem_addr=0x1010, mem_ce=1, mem_memwe=1, mem_memdata=0xAB.
- Reset mid-shift (SLL by 20, rst at cycle 3) -> next cycle all outputs 0, stall_req=0, state IDLE; a following ADD completes normally.
